// File: rtl/stepper_sysid_checker.sv
// System-ID read master: fetches ID and timestamp words after reset,
// and enables the stepper drive only when both match the build constants.
module stepper_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0400_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h544F_2ECA,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic        drive_enable
);

  typedef enum logic [1:0] {
    RD_ID,
    RD_TS,
    DONE,
    FAIL
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        armed;
  logic [15:0] wait_cnt;
  logic        reading;
  logic        accept;
  logic        stall;
  logic        expire;
  logic        restart;

  // armed holds the read strobe off for the first cycle out of reset
  assign reading = armed && (state == RD_ID || state == RD_TS);
  assign accept  = reading && !avm_waitrequest;
  assign stall   = reading && avm_waitrequest;
  assign expire  = stall && (wait_cnt == LIMIT);
  assign restart = start && (state == DONE || state == FAIL);

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RD_ID;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; an accept in the expiry cycle still counts
  always_comb begin
    state_next = state;
    unique case (state)
      RD_ID: begin
        if (accept) begin
          state_next = RD_TS;
        end else if (expire) begin
          state_next = FAIL;
        end
      end
      RD_TS: begin
        if (accept) begin
          state_next = DONE;
        end else if (expire) begin
          state_next = FAIL;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RD_ID;
        end
      end
      FAIL: begin
        if (start) begin
          state_next = RD_ID;
        end
      end
      default: state_next = RD_ID;
    endcase
  end

  // stall counter, captured words and compare flags
  always_ff @(posedge clock) begin
    if (reset) begin
      armed    <= 1'b0;
      wait_cnt <= '0;
      id_value <= '0;
      ts_value <= '0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (restart) begin
        wait_cnt <= '0;
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
      end else if (accept) begin
        wait_cnt <= '0;
        if (state == RD_ID) begin
          id_value <= avm_readdata;
          id_ok    <= (avm_readdata == EXPECTED_ID);
        end else begin
          ts_value <= avm_readdata;
          ts_ok    <= (avm_readdata == EXPECTED_TS);
        end
      end else if (stall) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

  // outputs decoded from registered state, so they change only on edges
  always_comb begin
    avm_read     = reading;
    avm_address  = (state == RD_TS);
    busy         = reading;
    done         = (state == DONE);
    timeout      = (state == FAIL);
    drive_enable = (state == DONE) && id_ok && ts_ok;
  end

endmodule

// File: tb/tb_stepper_sysid_checker.sv
// Bench for stepper_sysid_checker: table vectors, hand sequences and
// randomized checks against a per-check outcome model.
module tb_stepper_sysid_checker;

  localparam logic [31:0] EID   = 32'h0400_0000;
  localparam logic [31:0] ETS   = 32'h544F_2ECA;
  localparam int          T     = 8;
  localparam int          STUCK = 32'h7FFF_FFFF;

  typedef struct {
    logic        use_reset;
    logic [31:0] id_w;
    logic [31:0] ts_w;
    int          s_id;
    int          s_ts;
    int          fin;
    logic        done;
    logic        to;
    logic        id_ok;
    logic        ts_ok;
    logic        de;
    logic [31:0] id_v;
    logic [31:0] ts_v;
    int          n_acc;
  } vec_t;

  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic        drive_enable;

  int          cfg[2];
  logic [31:0] id_w;
  logic [31:0] ts_w;
  int          scnt;
  int          total = 0;
  int          pass = 0;
  int          viol;
  logic        prev_stall = 0;
  logic        prev_addr = 0;
  logic        prev_reset = 1;
  logic        acc_q[$];
  logic [31:0] m_id;
  logic [31:0] m_ts;

  stepper_sysid_checker #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .id_value(id_value),
    .ts_value(ts_value),
    .busy(busy),
    .done(done),
    .id_ok(id_ok),
    .ts_ok(ts_ok),
    .timeout(timeout),
    .drive_enable(drive_enable)
  );

  always #5 clock = ~clock;

  // slave model: stall cfg[addr] cycles, then accept
  assign avm_waitrequest = avm_read && (scnt < cfg[avm_address]);
  assign avm_readdata    = avm_address ? ts_w : id_w;

  always @(posedge clock) begin
    if (reset || !avm_read || !avm_waitrequest) scnt <= 0;
    else scnt <= scnt + 1;
  end

  // protocol monitor: accepted addresses and stall stability
  always @(negedge clock) begin
    if (prev_stall && !prev_reset && !timeout &&
        !(avm_read && avm_address == prev_addr))
      viol = viol + 1;
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
    prev_reset = reset;
    if (!reset && avm_read && !avm_waitrequest)
      acc_q.push_back(avm_address);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total = total + 1;
    if (act === exp) pass = pass + 1;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // outcome of one check from stall lengths and the timeout rule
  task automatic model(inout vec_t v);
    if (v.use_reset) begin
      m_id = '0;
      m_ts = '0;
    end
    v.id_ok = 0;
    v.ts_ok = 0;
    if (v.s_id >= T) begin
      v.fin   = 1 + T;
      v.n_acc = 0;
    end else begin
      m_id    = v.id_w;
      v.id_ok = (v.id_w == EID);
      if (v.s_ts >= T) begin
        v.fin   = 2 + v.s_id + T;
        v.n_acc = 1;
      end else begin
        m_ts    = v.ts_w;
        v.ts_ok = (v.ts_w == ETS);
        v.fin   = 3 + v.s_id + v.s_ts;
        v.n_acc = 2;
      end
    end
    v.done = (v.n_acc == 2);
    v.to   = !v.done;
    v.de   = v.done && v.id_ok && v.ts_ok;
    v.id_v = m_id;
    v.ts_v = m_ts;
  endtask

  task automatic run(input vec_t v, input string nm);
    int  fin;
    logic ord;
    fin    = -1;
    cfg[0] = v.s_id;
    cfg[1] = v.s_ts;
    id_w   = v.id_w;
    ts_w   = v.ts_w;
    acc_q.delete();
    viol = 0;
    if (v.use_reset) begin
      reset = 1;
      @(posedge clock);
      #1 reset = 0;
    end else begin
      start = 1;
    end
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock);
      #1 start = 0;
      if (k == 1) chk({nm, " go"}, {30'd0, avm_read, busy}, 32'd3);
      if (done || timeout) begin
        fin = k;
        break;
      end
    end
    chk({nm, " fin"}, fin, v.fin);
    chk({nm, " flags"},
        {27'd0, done, timeout, id_ok, ts_ok, drive_enable},
        {27'd0, v.done, v.to, v.id_ok, v.ts_ok, v.de});
    chk({nm, " id_value"}, id_value, v.id_v);
    chk({nm, " ts_value"}, ts_value, v.ts_v);
    chk({nm, " idle"}, {30'd0, avm_read, busy}, 32'd0);
    chk({nm, " n_acc"}, acc_q.size(), v.n_acc);
    ord = 1;
    foreach (acc_q[i]) if (acc_q[i] != i[0] || i > 1) ord = 0;
    chk({nm, " order"}, {31'd0, ord}, 32'd1);
    chk({nm, " stable"}, viol, 0);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    cfg[0] = 0;
    cfg[1] = 0;
    id_w   = EID;
    ts_w   = ETS;
    tbl[0] = '{1'b1, EID, ETS, 0, 0, 3, 1, 0, 1, 1, 1, EID, ETS, 2};
    tbl[1] = '{1'b1, 32'h0400_0001, ETS, 0, 0, 3, 1, 0, 0, 1, 0,
               32'h0400_0001, ETS, 2};
    tbl[2] = '{1'b1, EID, ETS, 5, 5, 13, 1, 0, 1, 1, 1, EID, ETS, 2};
    tbl[3] = '{1'b0, EID, ETS, 0, STUCK, 10, 0, 1, 1, 0, 0, EID, ETS, 1};
    tbl[4] = '{1'b0, EID, ETS, 0, 0, 3, 1, 0, 1, 1, 1, EID, ETS, 2};
    tbl[5] = '{1'b0, EID, ETS, 7, 0, 10, 1, 0, 1, 1, 1, EID, ETS, 2};
    tbl[6] = '{1'b0, EID, ETS, 8, 0, 9, 0, 1, 0, 0, 0, EID, ETS, 0};
    tbl[7] = '{1'b0, EID, 32'h544F_2ECB, 2, 3, 8, 1, 0, 1, 0, 0,
               EID, 32'h544F_2ECB, 2};
    tbl[8] = '{1'b0, EID, ETS, 0, 7, 10, 1, 0, 1, 1, 1, EID, ETS, 2};
    tbl[9] = '{1'b0, EID, ETS, 3, 8, 13, 0, 1, 1, 0, 0, EID, ETS, 1};

    // reset state, with start held high alongside reset
    reset = 1;
    start = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset ctl",
        {24'd0, avm_read, avm_address, busy, done, id_ok, ts_ok,
         timeout, drive_enable}, 32'd0);
    chk("reset id_value", id_value, 32'd0);
    chk("reset ts_value", ts_value, 32'd0);
    start = 0;

    foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

    // reset during the timestamp stall, start pulsed while busy
    cfg[0] = 0;
    cfg[1] = STUCK;
    reset  = 1;
    @(posedge clock);
    #1 reset = 0;
    repeat (3) @(posedge clock);
    #1 start = 1;
    @(posedge clock);
    #1 start = 0;
    chk("busy start ignored",
        {28'd0, busy, avm_read, avm_address, done}, 32'b1110);
    reset = 1;
    @(posedge clock);
    #1;
    chk("reset abandons read", {30'd0, avm_read, busy}, 32'd0);
    rv = '{1'b1, EID, ETS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    model(rv);
    run(rv, "restart");

    // randomized checks
    for (int n = 0; n < 24; n++) begin
      rv.use_reset = (n == 0) || ($urandom_range(0, 5) == 0);
      rv.id_w = $urandom_range(0, 1) ? EID
              : EID ^ (32'd1 << $urandom_range(0, 31));
      rv.ts_w = $urandom_range(0, 1) ? ETS
              : ETS ^ (32'd1 << $urandom_range(0, 31));
      rv.s_id = int'($urandom_range(0, 9));
      rv.s_ts = int'($urandom_range(0, 9));
      model(rv);
      run(rv, $sformatf("r%0d", n));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
